// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_pkg : shared constants and types for the writeback arbiter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_wb_arbiter_pkg;

   localparam int DEF_DEPTH = 32;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_AW    = $clog2(DEF_DEPTH);

   // Register x0 is hardwired; writes aimed at it are dropped on accept.
   localparam int X0_ADDR = 0;

   typedef struct packed {
      logic [DEF_AW-1:0]    addr;
      logic [DEF_WIDTH-1:0] data;
   } wb_req_t;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : one-hot round-robin grant with registered priority pointer
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
   parameter  int N  = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          adv,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] ptr
);

   logic [PW:0]   scan_idx;
   logic          found;
   logic [PW-1:0] winner;
   logic [PW-1:0] next_ptr;

   // Scan starts at ptr and wraps; the extra scan_idx bit absorbs ptr+k overflow.
   always_comb begin
      grant    = '0;
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int k = 0; k < N; k++) begin
         scan_idx = {1'b0, ptr} + (PW+1)'(k);
         if (scan_idx >= (PW+1)'(N)) begin
            scan_idx = scan_idx - (PW+1)'(N);
         end
         if (!found && req[scan_idx[PW-1:0]]) begin
            found                   = 1'b1;
            grant[scan_idx[PW-1:0]] = 1'b1;
            winner                  = scan_idx[PW-1:0];
         end
      end
   end

   assign next_ptr = (winner == PW'(N-1)) ? '0 : winner + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (adv && found) begin
         ptr <= next_ptr;
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter : buffers per-source writeback results and serialises
// them round-robin onto the register-file write port.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter  int N_SRC = 3,
   parameter  int DEPTH = DEF_DEPTH,
   parameter  int WIDTH = DEF_WIDTH,
   localparam int AW    = addr_width(DEPTH),
   localparam int PW    = $clog2(N_SRC)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [N_SRC-1:0]       src_valid,
   output logic [N_SRC-1:0]       src_ready,
   input  logic [N_SRC*AW-1:0]    src_waddr,
   input  logic [N_SRC*WIDTH-1:0] src_data,
   output logic                   wb_we,
   output logic [AW-1:0]          wb_waddr,
   output logic [WIDTH-1:0]       wb_data,
   output logic                   idle
);

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
   } req_t;

   logic [N_SRC-1:0] hold_v;
   req_t             hold_q [N_SRC];
   logic [N_SRC-1:0] grant;
   logic [N_SRC-1:0] capture;
   logic             any_grant;
   req_t             issue_req;
   logic [PW-1:0]    rr_ptr_unused;

   rr_arbiter #(
      .N (N_SRC)
   ) u_rr (
      .clk   (clk),
      .rst   (rst),
      .req   (hold_v),
      .adv   (~flush),
      .grant (grant),
      .ptr   (rr_ptr_unused)
   );

   assign any_grant = |grant;

   // Ready uses only registered state plus rst/flush, so valid never loops back.
   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      assign src_ready[i] = ~rst & ~flush & (~hold_v[i] | grant[i]);
      assign capture[i]   = src_valid[i] & src_ready[i]
                            & (src_waddr[i*AW +: AW] != AW'(X0_ADDR));
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         hold_v <= '0;
      end else begin
         hold_v <= capture | (hold_v & ~grant);
      end
      for (int i = 0; i < N_SRC; i++) begin
         if (capture[i]) begin
            hold_q[i] <= {src_waddr[i*AW +: AW], src_data[i*WIDTH +: WIDTH]};
         end
      end
   end

   always_comb begin
      issue_req = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant[i]) begin
            issue_req = hold_q[i];
         end
      end
   end

   // Address/data keep their last value when no write is presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_we    <= 1'b0;
         wb_waddr <= '0;
         wb_data  <= '0;
      end else if (flush) begin
         wb_we    <= 1'b0;
      end else if (any_grant) begin
         wb_we    <= 1'b1;
         wb_waddr <= issue_req.addr;
         wb_data  <= issue_req.data;
      end else begin
         wb_we    <= 1'b0;
      end
   end

   assign idle = ~|hold_v & ~wb_we;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter : directed and random stimulus against a reference model
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int W  = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [N-1:0]    src_valid;
   logic [N-1:0]    src_ready;
   logic [N*AW-1:0] src_waddr;
   logic [N*W-1:0]  src_data;
   logic            wb_we;
   logic [AW-1:0]   wb_waddr;
   logic [W-1:0]    wb_data;
   logic            idle;

   regfile_wb_arbiter #(
      .N_SRC (N),
      .DEPTH (32),
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_waddr (src_waddr),
      .src_data  (src_data),
      .wb_we     (wb_we),
      .wb_waddr  (wb_waddr),
      .wb_data   (wb_data),
      .idle      (idle)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: pending results per source, rotating priority, port value
   logic [N-1:0]  m_v;
   logic [AW-1:0] m_a [N];
   logic [W-1:0]  m_d [N];
   int            m_ptr;
   logic          m_we;
   logic [AW-1:0] m_wa;
   logic [W-1:0]  m_wd;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int model_grant();
      int i;
      for (int k = 0; k < N; k++) begin
         i = (m_ptr + k) % N;
         if (m_v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [N*AW-1:0] pa(input int a0, input int a1, input int a2);
      return {AW'(a2), AW'(a1), AW'(a0)};
   endfunction

   function automatic logic [N*W-1:0] pd(input int d0, input int d1, input int d2);
      return {W'(d2), W'(d1), W'(d0)};
   endfunction

   task automatic step(input logic r, input logic f, input logic [N-1:0] v,
                       input logic [N*AW-1:0] a, input logic [N*W-1:0] d);
      int           g;
      logic [N-1:0] rdy;
      @(negedge clk);
      check_val("wb_we",    64'(wb_we),    64'(m_we));
      check_val("wb_waddr", 64'(wb_waddr), 64'(m_wa));
      check_val("wb_data",  64'(wb_data),  64'(m_wd));
      check_val("idle",     64'(idle),     64'(~|m_v & ~m_we));
      rst       = r;
      flush     = f;
      src_valid = v;
      src_waddr = a;
      src_data  = d;
      #1;
      g = model_grant();
      for (int i = 0; i < N; i++) rdy[i] = !r && !f && (!m_v[i] || g == i);
      check_val("src_ready", 64'(src_ready), 64'(rdy));
      @(posedge clk);
      if (r) begin
         m_v = '0; m_ptr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
      end else if (f) begin
         m_v = '0; m_we = 1'b0;
      end else begin
         if (g >= 0) begin
            m_we = 1'b1; m_wa = m_a[g]; m_wd = m_d[g]; m_ptr = (g + 1) % N;
         end else begin
            m_we = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (v[i] && rdy[i] && a[i*AW +: AW] != '0) begin
               m_v[i] = 1'b1; m_a[i] = a[i*AW +: AW]; m_d[i] = d[i*W +: W];
            end else if (g == i) begin
               m_v[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic idle_steps(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; src_valid = '0; src_waddr = '0; src_data = '0;
      repeat (2) @(posedge clk);
      m_v = '0; m_ptr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
      for (int i = 0; i < N; i++) begin m_a[i] = '0; m_d[i] = '0; end

      // single source streaming
      step(1'b0, 1'b0, 3'b001, pa(1, 0, 0), pd('hA, 0, 0));
      step(1'b0, 1'b0, 3'b001, pa(2, 0, 0), pd('hB, 0, 0));
      step(1'b0, 1'b0, 3'b001, pa(3, 0, 0), pd('hC, 0, 0));
      idle_steps(4);

      // all three sources continuously valid from a fresh pointer
      step(1'b1, 1'b0, '0, '0, '0);
      for (int k = 0; k < 9; k++)
         step(1'b0, 1'b0, 3'b111, pa(5, 6, 7), pd(k, 'h100 + k, 'h200 + k));
      idle_steps(4);

      // x0 write dropped
      step(1'b0, 1'b0, 3'b010, pa(0, 0, 0), pd(0, 'hDEAD, 0));
      idle_steps(3);

      // flush with buffered entries
      step(1'b0, 1'b0, 3'b101, pa(4, 0, 8), pd('h44, 0, 'h88));
      step(1'b0, 1'b0, 3'b000, '0, '0);
      step(1'b0, 1'b1, 3'b101, pa(10, 0, 11), pd(1, 0, 2));
      idle_steps(3);

      // reset mid-operation, then simultaneous sources 0 and 2
      step(1'b0, 1'b0, 3'b111, pa(1, 2, 3), pd('h1, 'h2, 'h3));
      step(1'b0, 1'b0, 3'b000, '0, '0);
      step(1'b1, 1'b0, 3'b000, '0, '0);
      step(1'b0, 1'b0, 3'b101, pa(12, 0, 13), pd('h12, 0, 'h13));
      idle_steps(4);

      // same address from two sources with pointer at 1
      step(1'b1, 1'b0, '0, '0, '0);
      step(1'b0, 1'b0, 3'b001, pa(3, 0, 0), pd('h33, 0, 0));
      step(1'b0, 1'b0, 3'b011, pa(9, 9, 0), pd('h11, 'h22, 0));
      idle_steps(4);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         logic [N*AW-1:0] a;
         logic [N*W-1:0]  d;
         for (int i = 0; i < N; i++) begin
            a[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            d[i*W +: W]   = W'($urandom);
         end
         step($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
              N'($urandom), a, d);
      end
      idle_steps(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Collects writeback results from N_SRC execution units and serialises them onto the single synchronous write port of the architectural register file (we / waddr / rd).
- Each source gets a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter picks one buffered result per cycle and drives a registered write port.
- It is the producer end of the register-file write interface and sits between the execute/complete stage and the register file.

Parameters:
- N_SRC, 3, number of writeback sources (at least 2).
- DEPTH, 32, register count; AW = $clog2(DEPTH).
- WIDTH, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all buffered, not-yet-issued results
- src_valid  in  N_SRC  per-source result valid
- src_ready  out  N_SRC  per-source buffer can accept
- src_waddr  in  N_SRC*AW  packed destination registers; source i at [i*AW +: AW]
- src_data  in  N_SRC*WIDTH  packed result data; source i at [i*WIDTH +: WIDTH]
- wb_we  out  1  register-file write enable
- wb_waddr  out  AW  register-file write address
- wb_data  out  WIDTH  register-file write data
- idle  out  1  no buffered entry and wb_we low

Interface: reset rst, synchronous, active-high; clock clk.

Behaviour:
- State per source i: hold_v[i], hold_addr[i], hold_data[i]. Shared state: rr_ptr (range 0..N_SRC-1). Output registers: wb_we, wb_waddr, wb_data.
- Reset (rst high at an edge): all hold_v = 0, rr_ptr = 0, wb_we = 0, wb_waddr = 0, wb_data = 0. While rst is high, src_ready = 0. Reset mid-operation loses buffered results; this is intended.
- Grant (combinational):
  - Scan hold_v starting at rr_ptr, wrapping modulo N_SRC.
  - The first set bit gets grant[i]. At most one grant per cycle. No grant if hold_v is all zero.
- Ready: src_ready[i] = ~rst & ~flush & (~hold_v[i] | grant[i]). It depends only on registered state plus rst/flush, never on src_valid, so there is no combinational loop.
- Accept: a handshake is src_valid[i] & src_ready[i].
  - On handshake with src_waddr != 0, hold_v[i] <= 1 and addr/data are captured.
  - On handshake with src_waddr == 0, the transfer completes but nothing is captured (x0 writes are dropped).
- Release: if grant[i] and source i has no new capturing handshake, hold_v[i] <= 0. Grant and a new capture in the same cycle leave hold_v[i] = 1 with the new contents.
- Issue: at the edge ending a cycle with any grant:
  - wb_we <= 1, wb_waddr <= hold_addr[g], wb_data <= hold_data[g];
  - rr_ptr <= (g+1) mod N_SRC.
  - With no grant: wb_we <= 0, wb_waddr/wb_data hold their previous values, rr_ptr unchanged.
- Latency: a handshake in cycle c gives wb_we = 1 in cycle c+2 at the earliest. Extra delay equals the number of cycles lost in arbitration.
- Throughput: one register-file write per cycle in aggregate. A lone source can stream one result per cycle.
- Fairness: any buffered entry is granted within N_SRC cycles.
- flush (synchronous, lower priority than rst):
  - Next edge: all hold_v <= 0 and wb_we <= 0. The write being presented during the flush cycle still completes.
  - rr_ptr unchanged. src_ready = 0 during the flush cycle, so no capture occurs.
- Same waddr from two sources: both are written, in grant order, so the later grant wins in the register file. Ordering among sources is the issuer's responsibility.
- idle = ~|hold_v & ~wb_we.
- Output registers are driven directly by flops; no combinational path from src_* to wb_*.

Decomposition:
- Shared package holds:
  - AW derivation via $clog2(DEPTH);
  - a wb_req typedef {addr[AW], data[WIDTH]};
  - the X0 address constant 0.
- Sub-module rr_arbiter (N parameter):
  - inputs req[N], adv; outputs grant[N] (one-hot) and the registered pointer;
  - the pointer updates to winner+1 when adv is high;
  - reset is synchronous.
- Holding buffers and output registers use the existing register primitives with reset and clock enable.

Test Plan:
- Single source 0 streams waddr 1,2,3 with data 0xA,0xB,0xC on consecutive cycles -> wb_we high for 3 consecutive cycles starting 2 cycles after the first handshake; writes (1,0xA),(2,0xB),(3,0xC) in order; src_ready[0] stays 1.
- All 3 sources assert in the same cycle (waddr 5/6/7, rr_ptr=0) and hold valid with new data -> grants cycle 0,1,2,0,1,2…; each src_ready[i] high only on its grant cycle; no starvation.
- Source 1 sends waddr 0 with data 0xDEAD -> handshake completes, wb_we never asserts for it, idle stays 1.
- Sources 0 and 2 fill their buffers, then flush is pulsed one cycle -> any write already on the port completes; afterwards wb_we = 0, idle = 1, src_ready = 0 during the flush cycle; the buffered entries are never written.
- rst asserted while 2 entries are buffered and wb_we = 1 -> next cycle wb_we = 0, wb_waddr = 0, wb_data = 0, rr_ptr = 0; the first post-reset simultaneous requests from sources 0 and 2 are granted to source 0 first.
- Sources 0 and 1 both write waddr 9 (0x11, 0x22) in the same cycle with rr_ptr=1 -> (9,0x22) issued before (9,0x11).
